q_frag_pipe: RTL
================

Name: q_frag_pipe

Overview:
- Parametrised successor to the single-bit logic-cell flip-flop fragment.
- WIDTH-bit, DEPTH-stage elastic register pipeline with a per-stage valid bit and valid/ready handshakes on both ends.
- Keeps the fragment's selectable set/clear controls and its clear-over-set priority, now as synchronous pipeline preload and flush.
- Used as the whitebox register-chain model for multi-bit, multi-stage Q-fragment packing in the logic tile.

Parameters:
- WIDTH, 8, data width of every stage.
- DEPTH, 2, number of stages; legal range 1..16.
- CNT_W, 5, width of OCC; must satisfy 2^CNT_W > DEPTH.
- SET_VALUE, {WIDTH{1'b1}}, stage data loaded by a synchronous set.
- RESET_VALUE, {WIDTH{1'b0}}, stage data after async reset or synchronous clear.

Ports:
- QCK  in  1  clock; all state changes on its rising edge.
- QRT  in  1  reset; asynchronous, active-high; clears the whole pipeline.
- QST  in  1  fabric synchronous set (preload).
- UQST  in  1  user synchronous set.
- QSTS  in  1  set select: 1 selects UQST, 0 selects QST.
- UQRT  in  1  synchronous clear (flush).
- QEN  in  1  global enable; 0 freezes the pipeline.
- QDI  in  WIDTH  input data.
- QDI_VLD  in  1  input valid.
- QDI_RDY  out  1  input ready.
- AQZ  out  WIDTH  output data (last stage).
- AQZ_VLD  out  1  output valid.
- AQZ_RDY  in  1  downstream ready.
- OCC  out  CNT_W  number of valid stages.

Behaviour:
- Clock is QCK. Reset QRT is asynchronous and active-high.
- QRT high: every stage data = RESET_VALUE, every valid = 0, OCC = 0, AQZ = RESET_VALUE, AQZ_VLD = 0, QDI_RDY = 0.
- After QRT deasserts, QDI_RDY = QEN.
- set_sel = QSTS ? UQST : QST. clr = UQRT.
- Control priority per edge: clr > set_sel > normal operation. The same ordering holds with QRT above all.
- clr (ignores QEN): all valids 0, all data RESET_VALUE, OCC 0. No input is accepted and no output is popped that cycle.
- set_sel without clr (ignores QEN): all data SET_VALUE, all valids 1, OCC = DEPTH. No accept or pop that cycle.
- QDI_RDY and AQZ_VLD are forced to 0 combinationally while clr, set_sel or QEN = 0 is present.
- AQZ_VLD = valid[DEPTH-1] & QEN & ~clr & ~set_sel. AQZ always shows stage DEPTH-1 data.
- Normal operation (QEN = 1, no clr/set):
  - pop = AQZ_VLD & AQZ_RDY.
  - Stage k moves into stage k+1 when valid[k] and stage k+1 is empty or moving out this cycle (bubble collapse).
  - QDI_RDY = stage 0 empty or stage 0 moving.
  - push = QDI_VLD & QDI_RDY loads QDI into stage 0 with valid = 1.
  - A stage left by a move and not refilled gets valid = 0; its data holds.
  - Data never overtakes; order is strictly FIFO.
- Latency: a word pushed on edge t into an empty pipeline is on AQZ with AQZ_VLD = 1 after edge t + DEPTH - 1. For DEPTH = 1 that is immediately after edge t.
- Throughput: one word per cycle while AQZ_RDY = 1.
- Full pipeline (OCC = DEPTH): QDI_RDY = AQZ_RDY. Push and pop on the same edge leaves OCC unchanged.
- OCC update each edge: OCC + push - pop. It saturates by construction and never exceeds DEPTH or goes below 0.
- QEN = 0: every data, valid and OCC register holds. Set and clear still act.
- QDI_RDY depends combinationally on AQZ_RDY. There is no combinational path from QDI or QDI_VLD to any output.
- QRT asserted mid-transfer discards all in-flight words. A handshake coincident with QRT assertion is lost.
- QSTS switching has effect in the same cycle, because it is a pure mux.

Test Plan:
- Reset/idle: QRT pulse with QEN = 1, DEPTH = 2 -> AQZ = 0x00, AQZ_VLD = 0, OCC = 0, QDI_RDY = 0 during reset and 1 after.
- Streaming: push 0x11, 0x22, 0x33 on consecutive edges with AQZ_RDY = 1 -> 0x11 on AQZ after the 2nd edge, then one word per cycle in order. OCC stays at most 2.
- Backpressure/fill: AQZ_RDY = 0, push 0xA1, 0xA2, 0xA3 -> OCC = 2, QDI_RDY = 0, 0xA3 not accepted. Then AQZ_RDY = 1 with 0xA3 valid -> pop 0xA1 and push 0xA3 on the same edge, OCC stays 2.
- Set/clear priority: OCC = 1. QSTS = 1, UQST = 1 -> all stages 0xFF, OCC = 2. Next cycle UQRT = 1 and QST = 1 -> OCC = 0, AQZ = 0x00.
- Stall: QEN = 0 with OCC = 2 and AQZ_RDY = 1 for 3 cycles -> no pop, state frozen, AQZ_VLD = 0. QEN back to 1 -> pop resumes with no data lost.
- Async reset mid-stream: QRT asserted between edges with OCC = 2 -> AQZ_VLD = 0 and OCC = 0 immediately, without waiting for an edge.

Source files
------------

// File: rtl/q_frag_pipe.sv
// q_frag_pipe: WIDTH-bit, DEPTH-stage elastic register pipeline.
// Each stage carries a valid bit. Words move forward whenever the next
// stage is empty or draining, so bubbles collapse. Input and output both
// use valid/ready handshakes.
// Synchronous clear (flush) and a selectable synchronous set (preload)
// override the global enable. Clear wins over set, and QRT overrides
// everything asynchronously.

module q_frag_pipe #(
  parameter int               WIDTH       = 8,
  parameter int               DEPTH       = 2,
  parameter int               CNT_W       = 5,
  parameter logic [WIDTH-1:0] SET_VALUE   = {WIDTH{1'b1}},
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
  input  logic             QCK,
  input  logic             QRT,
  input  logic             QST,
  input  logic             UQST,
  input  logic             QSTS,
  input  logic             UQRT,
  input  logic             QEN,
  input  logic [WIDTH-1:0] QDI,
  input  logic             QDI_VLD,
  output logic             QDI_RDY,
  output logic [WIDTH-1:0] AQZ,
  output logic             AQZ_VLD,
  input  logic             AQZ_RDY,
  output logic [CNT_W-1:0] OCC
);

  logic [WIDTH-1:0] stage_data [DEPTH];
  logic [DEPTH-1:0] stage_vld;
  logic [CNT_W-1:0] occ_q;

  logic             set_sel;
  logic             clr;
  logic             run;
  logic             pop;
  logic             push;
  logic [DEPTH-1:0] move;

  // Control decode, handshakes and per-stage move decisions, last stage first
  always_comb begin
    set_sel = QSTS ? UQST : QST;
    clr     = UQRT;
    run     = QEN & ~clr & ~set_sel & ~QRT;
    AQZ_VLD = stage_vld[DEPTH-1] & run;
    pop     = AQZ_VLD & AQZ_RDY;
    move    = '0;
    move[DEPTH-1] = pop;
    for (int k = DEPTH - 2; k >= 0; k--) begin
      move[k] = run & stage_vld[k] & (~stage_vld[k+1] | move[k+1]);
    end
    QDI_RDY = run & (~stage_vld[0] | move[0]);
    push    = QDI_VLD & QDI_RDY;
  end

  // Stage registers and occupancy: reset, then clear, then set, then shifting
  always_ff @(posedge QCK or posedge QRT) begin
    if (QRT) begin
      for (int k = 0; k < DEPTH; k++) begin
        stage_data[k] <= RESET_VALUE;
      end
      stage_vld <= '0;
      occ_q     <= '0;
    end else if (clr) begin
      for (int k = 0; k < DEPTH; k++) begin
        stage_data[k] <= RESET_VALUE;
      end
      stage_vld <= '0;
      occ_q     <= '0;
    end else if (set_sel) begin
      for (int k = 0; k < DEPTH; k++) begin
        stage_data[k] <= SET_VALUE;
      end
      stage_vld <= '1;
      occ_q     <= CNT_W'(DEPTH);
    end else begin
      if (push) begin
        stage_data[0] <= QDI;
        stage_vld[0]  <= 1'b1;
      end else if (move[0]) begin
        stage_vld[0]  <= 1'b0;
      end
      for (int k = 1; k < DEPTH; k++) begin
        if (move[k-1]) begin
          stage_data[k] <= stage_data[k-1];
          stage_vld[k]  <= 1'b1;
        end else if (move[k]) begin
          stage_vld[k]  <= 1'b0;
        end
      end
      occ_q <= occ_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  assign AQZ = stage_data[DEPTH-1];
  assign OCC = occ_q;

endmodule
